// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared types and defaults for the memory port arbiter
package mem_port_arbiter_pkg;

    // Arbiter ownership phases: waiting for a request, presenting it downstream, collecting beats.
    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2
    } arb_state_e;

    localparam int DEF_DATA_WIDTH = 64;
    localparam int DEF_ADDR_WIDTH = 64;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - requester, downstream and status signals of the shared memory port
interface mem_port_arbiter_if
    import mem_port_arbiter_pkg::*;
#(
    parameter int N          = 2,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int SEL_WIDTH  = $clog2(N)
);
    logic [N-1:0]                 req_valid;
    logic [N-1:0]                 req_ready;
    logic [N-1:0][ADDR_WIDTH-1:0] req_addr;
    logic [N-1:0]                 req_wr;
    logic [N-1:0][DATA_WIDTH-1:0] req_wdata;
    logic [N-1:0]                 resp_valid;
    logic                         resp_last;
    logic [DATA_WIDTH-1:0]        resp_data;
    logic                         mem_req_valid;
    logic                         mem_req_ready;
    logic [ADDR_WIDTH-1:0]        mem_addr;
    logic                         mem_wr;
    logic [DATA_WIDTH-1:0]        mem_wdata;
    logic                         mem_resp_valid;
    logic                         mem_resp_last;
    logic [DATA_WIDTH-1:0]        mem_resp_data;
    logic [SEL_WIDTH-1:0]         grant_sel;
    logic                         busy;

    // Arbiter side.
    modport master (
        input  req_valid, req_addr, req_wr, req_wdata,
        input  mem_req_ready, mem_resp_valid, mem_resp_last, mem_resp_data,
        output req_ready, resp_valid, resp_last, resp_data,
        output mem_req_valid, mem_addr, mem_wr, mem_wdata, grant_sel, busy
    );

    // Requesters plus downstream memory side.
    modport slave (
        output req_valid, req_addr, req_wr, req_wdata,
        output mem_req_ready, mem_resp_valid, mem_resp_last, mem_resp_data,
        input  req_ready, resp_valid, resp_last, resp_data,
        input  mem_req_valid, mem_addr, mem_wr, mem_wdata, grant_sel, busy
    );
endinterface

// File: rtl/mem_port_arbiter_mux.sv
// rtl/mem_port_arbiter_mux.sv - generic N-input mux steering one requester field onto the port
module mem_port_arbiter_mux #(
    parameter int N         = 2,
    parameter int W         = 64,
    parameter int SEL_WIDTH = $clog2(N)
) (
    input  logic [N-1:0][W-1:0]  in_data,
    input  logic [SEL_WIDTH-1:0] sel,
    output logic [W-1:0]         out_data
);
    assign out_data = in_data[sel];
endmodule

// File: rtl/mem_port_arbiter_rr_picker.sv
// rtl/mem_port_arbiter_rr_picker.sv - round-robin pick of the next requester after last_grant
module mem_port_arbiter_rr_picker #(
    parameter int N         = 2,
    parameter int SEL_WIDTH = $clog2(N)
) (
    input  logic [N-1:0]         req,
    input  logic [SEL_WIDTH-1:0] last_grant,
    output logic                 any,
    output logic [SEL_WIDTH-1:0] pick
);
    logic [N-1:0] rot;
    logic         found;

    assign any = |req;

    // Rotate so bit 0 is the requester after last_grant, then take the first set bit.
    // When last_grant+1 wraps (power-of-two N) or equals N, the shift lands back on req itself.
    always_comb begin
        rot   = N'({req, req} >> (last_grant + SEL_WIDTH'(1)));
        pick  = '0;
        found = 1'b0;
        for (int j = 0; j < N; j++) begin
            if (!found && rot[j]) begin
                found = 1'b1;
                pick  = SEL_WIDTH'((int'(last_grant) + 1 + j) % N);
            end
        end
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin, non-preemptive owner of one shared memory port
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int N          = 2,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int SEL_WIDTH  = $clog2(N)
) (
    input  logic               clk,
    input  logic               reset,
    mem_port_arbiter_if.master bus
);
    arb_state_e           state, state_nx;
    logic [SEL_WIDTH-1:0] last_grant, last_grant_nx;
    logic [SEL_WIDTH-1:0] grant_q, grant_nx;
    logic                 req_any;
    logic [SEL_WIDTH-1:0] req_pick;

    mem_port_arbiter_rr_picker #(.N(N), .SEL_WIDTH(SEL_WIDTH)) u_picker (
        .req        (bus.req_valid),
        .last_grant (last_grant),
        .any        (req_any),
        .pick       (req_pick)
    );

    mem_port_arbiter_mux #(.N(N), .W(ADDR_WIDTH), .SEL_WIDTH(SEL_WIDTH)) u_addr_mux (
        .in_data  (bus.req_addr),
        .sel      (grant_q),
        .out_data (bus.mem_addr)
    );

    mem_port_arbiter_mux #(.N(N), .W(DATA_WIDTH), .SEL_WIDTH(SEL_WIDTH)) u_wdata_mux (
        .in_data  (bus.req_wdata),
        .sel      (grant_q),
        .out_data (bus.mem_wdata)
    );

    assign bus.mem_wr    = bus.req_wr[grant_q];
    assign bus.grant_sel = grant_q;
    assign bus.resp_data = bus.mem_resp_data;
    assign bus.resp_last = bus.mem_resp_last;

    // State, owner and round-robin pointer; reset abandons any in-flight transaction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ARB_IDLE;
            last_grant <= SEL_WIDTH'(N - 1);
            grant_q    <= '0;
        end else begin
            state      <= state_nx;
            last_grant <= last_grant_nx;
            grant_q    <= grant_nx;
        end
    end

    // Next state plus owner-only request/response routing.
    always_comb begin
        state_nx          = state;
        last_grant_nx     = last_grant;
        grant_nx          = grant_q;
        bus.req_ready     = '0;
        bus.resp_valid    = '0;
        bus.mem_req_valid = 1'b0;
        bus.busy          = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (req_any) begin
                    grant_nx = req_pick;
                    state_nx = ARB_ISSUE;
                end
            end
            ARB_ISSUE: begin
                bus.busy               = 1'b1;
                bus.mem_req_valid      = bus.req_valid[grant_q];
                bus.req_ready[grant_q] = bus.mem_req_ready;
                if (bus.req_valid[grant_q] && bus.mem_req_ready) begin
                    state_nx = ARB_WAIT;
                end else if (!bus.req_valid[grant_q]) begin
                    // Owner withdrew before the handshake: give up without moving the pointer.
                    state_nx = ARB_IDLE;
                end
            end
            ARB_WAIT: begin
                bus.busy                = 1'b1;
                bus.resp_valid[grant_q] = bus.mem_resp_valid;
                if (bus.mem_resp_valid && bus.mem_resp_last) begin
                    last_grant_nx = grant_q;
                    state_nx      = ARB_IDLE;
                end
            end
            default: state_nx = ARB_IDLE;
        endcase
    end

    // A response beat is only meaningful while a transaction is outstanding.
    assert property (@(posedge clk) disable iff (reset) bus.mem_resp_valid |-> state == ARB_WAIT);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed scoreboard bench for mem_port_arbiter (N=2 and N=4)
module tb_mem_port_arbiter;
    localparam int AW4 = 16;
    localparam int DW4 = 16;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   vectors     = 0;
    int   miscompares = 0;
    int   lat;

    typedef struct {
        int          sel;
        logic [63:0] addr;
        logic        wr;
        logic [63:0] wdata;
    } txn_t;

    txn_t        exp_q[$];
    logic [63:0] rsp_q[$];

    mem_port_arbiter_if #(.N(2), .DATA_WIDTH(64), .ADDR_WIDTH(64)) b2 ();
    mem_port_arbiter_if #(.N(4), .DATA_WIDTH(DW4), .ADDR_WIDTH(AW4)) b4 ();

    mem_port_arbiter #(.N(2), .DATA_WIDTH(64), .ADDR_WIDTH(64)) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (b2.master)
    );

    mem_port_arbiter #(.N(4), .DATA_WIDTH(DW4), .ADDR_WIDTH(AW4)) dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (b4.master)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish, expected finish before 200000");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic raise(input int i, input logic [63:0] addr, input logic wr, input logic [63:0] wdata);
        txn_t t;
        b2.req_addr[i]  = addr;
        b2.req_wr[i]    = wr;
        b2.req_wdata[i] = wdata;
        b2.req_valid[i] = 1'b1;
        t.sel = i; t.addr = addr; t.wr = wr; t.wdata = wdata;
        exp_q.push_back(t);
    endtask

    // Pop the next expected transaction, wait for it downstream, stall, handshake, return beats.
    task automatic serve(input int beats, input int stall, output int latency);
        txn_t        e;
        logic [63:0] d;
        logic [63:0] got;
        latency = 0;
        chk("sb_pending", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() == 0) return;
        e = exp_q.pop_front();
        b2.mem_req_ready = (stall == 0);
        @(negedge clk);
        while (b2.mem_req_valid !== 1'b1 && latency < 10) begin
            @(negedge clk);
            latency++;
        end
        chk("mem_req_valid", 64'(b2.mem_req_valid), 64'd1);
        chk("grant_sel", 64'(b2.grant_sel), 64'(e.sel));
        for (int s = 0; s < stall; s++) begin
            chk("stall_valid", 64'(b2.mem_req_valid), 64'd1);
            chk("stall_addr", b2.mem_addr, e.addr);
            chk("stall_ready", 64'(b2.req_ready), 64'd0);
            nxt();
            if (s == stall - 1) b2.mem_req_ready = 1'b1;
            @(negedge clk);
        end
        chk("mem_addr", b2.mem_addr, e.addr);
        chk("mem_wr", 64'(b2.mem_wr), 64'(e.wr));
        chk("mem_wdata", b2.mem_wdata, e.wdata);
        chk("req_ready", 64'(b2.req_ready), 64'd1 << e.sel);
        chk("busy_issue", 64'(b2.busy), 64'd1);
        nxt();
        b2.req_valid[e.sel] = 1'b0;
        b2.mem_req_ready    = 1'b0;
        for (int k = 0; k < beats; k++) begin
            d = e.addr ^ 64'(k) ^ 64'hA5A5_0000_0000_0000;
            rsp_q.push_back(d);
            b2.mem_resp_valid = 1'b1;
            b2.mem_resp_last  = (k == beats - 1);
            b2.mem_resp_data  = d;
            @(negedge clk);
            got = rsp_q.pop_front();
            chk("resp_valid", 64'(b2.resp_valid), 64'd1 << e.sel);
            chk("resp_data", b2.resp_data, got);
            chk("resp_last", 64'(b2.resp_last), 64'(k == beats - 1));
            nxt();
        end
        b2.mem_resp_valid = 1'b0;
        b2.mem_resp_last  = 1'b0;
    endtask

    initial begin
        b2.req_valid = '0; b2.req_addr = '0; b2.req_wr = '0; b2.req_wdata = '0;
        b2.mem_req_ready = 1'b0; b2.mem_resp_valid = 1'b0; b2.mem_resp_last = 1'b0; b2.mem_resp_data = '0;
        b4.req_valid = '0; b4.req_addr = '0; b4.req_wr = '0; b4.req_wdata = '0;
        b4.mem_req_ready = 1'b0; b4.mem_resp_valid = 1'b0; b4.mem_resp_last = 1'b0; b4.mem_resp_data = '0;

        // Reset state.
        @(negedge clk);
        chk("rst_busy", 64'(b2.busy), 64'd0);
        chk("rst_grant", 64'(b2.grant_sel), 64'd0);
        chk("rst_mem_req_valid", 64'(b2.mem_req_valid), 64'd0);
        chk("rst_req_ready", 64'(b2.req_ready), 64'd0);
        chk("rst_resp_valid", 64'(b2.resp_valid), 64'd0);
        chk("rst4_grant", 64'(b4.grant_sel), 64'd0);
        nxt();
        reset = 1'b0;

        // 1: both request, 0 first, then 1 one IDLE cycle after completion.
        raise(0, 64'h0000_1000_0000_0040, 1'b0, 64'h0);
        raise(1, 64'h0000_2000_0000_0080, 1'b1, 64'h1111_2222_3333_4444);
        serve(1, 0, lat);
        serve(1, 0, lat);
        chk("t1_rearb_latency", 64'(lat), 64'd1);

        // 2: single request, ISSUE in cycle 1, response cycle 2, IDLE cycle 3.
        raise(1, 64'h0000_3000_0000_00C0, 1'b0, 64'h0);
        serve(1, 0, lat);
        chk("t2_issue_latency", 64'(lat), 64'd1);
        @(negedge clk);
        chk("t2_idle_busy", 64'(b2.busy), 64'd0);
        nxt();

        // 3: five stalled ISSUE cycles, then handshake.
        raise(0, 64'h0000_4000_0000_0100, 1'b1, 64'hDEAD_BEEF_0000_0001);
        serve(1, 5, lat);

        // 4: four-beat read for 0 while 1 waits, then 1.
        raise(0, 64'h0000_5000_0000_0140, 1'b0, 64'h0);
        nxt();
        raise(1, 64'h0000_6000_0000_0180, 1'b0, 64'h0);
        serve(4, 0, lat);
        serve(1, 0, lat);
        chk("t4_next_owner_latency", 64'(lat), 64'd1);

        // 5: leave the pointer at 0, reset in WAIT of owner 1, then first grant must be 0.
        raise(0, 64'h0000_7000_0000_01C0, 1'b0, 64'h0);
        serve(1, 0, lat);
        raise(1, 64'h0000_8000_0000_0200, 1'b0, 64'h0);
        void'(exp_q.pop_front());
        b2.mem_req_ready = 1'b1;
        nxt();
        nxt();
        b2.req_valid[1] = 1'b0;
        b2.mem_req_ready = 1'b0;
        b2.mem_resp_valid = 1'b1;
        b2.mem_resp_data = 64'h77;
        @(negedge clk);
        chk("t5_wait_resp_valid", 64'(b2.resp_valid), 64'd2);
        #1 reset = 1'b1;
        #1;
        chk("t5_rst_busy", 64'(b2.busy), 64'd0);
        chk("t5_rst_resp_valid", 64'(b2.resp_valid), 64'd0);
        chk("t5_rst_mem_req_valid", 64'(b2.mem_req_valid), 64'd0);
        chk("t5_rst_grant", 64'(b2.grant_sel), 64'd0);
        b2.mem_resp_valid = 1'b0;
        nxt();
        reset = 1'b0;
        raise(0, 64'h0000_9000_0000_0240, 1'b0, 64'h0);
        raise(1, 64'h0000_A000_0000_0280, 1'b1, 64'h5555_6666_7777_8888);
        serve(1, 0, lat);
        serve(1, 0, lat);

        // 6: N=4, pointer at 3, req 1001 -> 0; again 1001 -> 3; withdrawal keeps pointer.
        b4.req_addr[0] = 16'h1000;
        b4.req_addr[3] = 16'h3000;
        b4.req_valid = 4'b1001;
        b4.mem_req_ready = 1'b1;
        @(negedge clk);
        chk("t6_idle_busy", 64'(b4.busy), 64'd0);
        nxt();
        @(negedge clk);
        chk("t6_grant0", 64'(b4.grant_sel), 64'd0);
        chk("t6_addr0", 64'(b4.mem_addr), 64'h1000);
        chk("t6_ready0", 64'(b4.req_ready), 64'b0001);
        nxt();
        b4.mem_req_ready = 1'b0;
        b4.mem_resp_valid = 1'b1;
        b4.mem_resp_last = 1'b1;
        b4.mem_resp_data = 16'hBEEF;
        @(negedge clk);
        chk("t6_resp_valid0", 64'(b4.resp_valid), 64'b0001);
        chk("t6_resp_data0", 64'(b4.resp_data), 64'hBEEF);
        nxt();
        b4.mem_resp_valid = 1'b0;
        b4.mem_resp_last = 1'b0;
        @(negedge clk);
        chk("t6_idle_after", 64'(b4.busy), 64'd0);
        nxt();
        @(negedge clk);
        chk("t6_grant3", 64'(b4.grant_sel), 64'd3);
        chk("t6_addr3", 64'(b4.mem_addr), 64'h3000);
        chk("t6_stall_ready3", 64'(b4.req_ready), 64'd0);
        nxt();
        b4.req_valid[3] = 1'b0;
        @(negedge clk);
        chk("t6_withdraw_valid", 64'(b4.mem_req_valid), 64'd0);
        nxt();
        b4.req_valid[3] = 1'b1;
        @(negedge clk);
        chk("t6_withdraw_idle", 64'(b4.busy), 64'd0);
        b4.mem_req_ready = 1'b1;
        nxt();
        @(negedge clk);
        chk("t6_regrant3", 64'(b4.grant_sel), 64'd3);
        chk("t6_ready3", 64'(b4.req_ready), 64'b1000);
        nxt();
        b4.req_valid = '0;
        b4.mem_req_ready = 1'b0;
        b4.mem_resp_valid = 1'b1;
        b4.mem_resp_last = 1'b1;
        b4.mem_resp_data = 16'hCAFE;
        @(negedge clk);
        chk("t6_resp_valid3", 64'(b4.resp_valid), 64'b1000);
        nxt();
        b4.mem_resp_valid = 1'b0;
        b4.mem_resp_last = 1'b0;
        nxt();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
